// File: rtl/axi_lite_to_axi_bridge.sv
// AXI4-Lite slave to AXI4 master bridge, one beat per transaction.
// Each of the five channels passes through a 1-entry register slice.
// The AXI4-only fields are tied to constants.
// Optional build macro AXI_LITE_TO_AXI_RESP_CHECK_EN: a B or R beat whose
// id is non-zero, or an R beat with last=0, is returned with resp=SLVERR.
// Handshake rule on every port: a beat moves on a clock edge where valid and
// ready are both 1. Valid never drops and payload never changes until that
// edge. Ready may depend combinationally on the downstream ready.

module axi_lite_to_axi_bridge_slice #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    // A free slot exists when the slice is empty or is draining this cycle.
    // Ready stays low while reset is held.
    assign in_ready_o  = !rst_i && (!full_q || out_ready_i);
    assign out_valid_o = full_q;
    assign out_data_o  = data_q;

    // Next state: a pop clears full, and a push sets it again with new payload.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (full_q && out_ready_i) begin
            full_d = 1'b0;
        end
        if (in_valid_i && in_ready_o) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end
    end

    // Slice state register. Reset drops any buffered beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end
endmodule

module axi_lite_to_axi_bridge #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 8,
    parameter int UW = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    // AXI4-Lite slave port
    input  logic [AW-1:0]   slv_aw_addr_i,
    input  logic [2:0]      slv_aw_prot_i,
    input  logic [3:0]      slv_aw_cache_i,
    input  logic            slv_aw_valid_i,
    output logic            slv_aw_ready_o,
    input  logic [DW-1:0]   slv_w_data_i,
    input  logic [DW/8-1:0] slv_w_strb_i,
    input  logic            slv_w_valid_i,
    output logic            slv_w_ready_o,
    output logic [1:0]      slv_b_resp_o,
    output logic            slv_b_valid_o,
    input  logic            slv_b_ready_i,
    input  logic [AW-1:0]   slv_ar_addr_i,
    input  logic [2:0]      slv_ar_prot_i,
    input  logic [3:0]      slv_ar_cache_i,
    input  logic            slv_ar_valid_i,
    output logic            slv_ar_ready_o,
    output logic [DW-1:0]   slv_r_data_o,
    output logic [1:0]      slv_r_resp_o,
    output logic            slv_r_valid_o,
    input  logic            slv_r_ready_i,
    // AXI4 master port
    output logic [IW-1:0]   mst_aw_id_o,
    output logic [AW-1:0]   mst_aw_addr_o,
    output logic [7:0]      mst_aw_len_o,
    output logic [2:0]      mst_aw_size_o,
    output logic [1:0]      mst_aw_burst_o,
    output logic            mst_aw_lock_o,
    output logic [3:0]      mst_aw_cache_o,
    output logic [2:0]      mst_aw_prot_o,
    output logic [3:0]      mst_aw_qos_o,
    output logic [3:0]      mst_aw_region_o,
    output logic [5:0]      mst_aw_atop_o,
    output logic [UW-1:0]   mst_aw_user_o,
    output logic            mst_aw_valid_o,
    input  logic            mst_aw_ready_i,
    output logic [DW-1:0]   mst_w_data_o,
    output logic [DW/8-1:0] mst_w_strb_o,
    output logic            mst_w_last_o,
    output logic [UW-1:0]   mst_w_user_o,
    output logic            mst_w_valid_o,
    input  logic            mst_w_ready_i,
    input  logic [IW-1:0]   mst_b_id_i,
    input  logic [1:0]      mst_b_resp_i,
    input  logic [UW-1:0]   mst_b_user_i,
    input  logic            mst_b_valid_i,
    output logic            mst_b_ready_o,
    output logic [IW-1:0]   mst_ar_id_o,
    output logic [AW-1:0]   mst_ar_addr_o,
    output logic [7:0]      mst_ar_len_o,
    output logic [2:0]      mst_ar_size_o,
    output logic [1:0]      mst_ar_burst_o,
    output logic            mst_ar_lock_o,
    output logic [3:0]      mst_ar_cache_o,
    output logic [2:0]      mst_ar_prot_o,
    output logic [3:0]      mst_ar_qos_o,
    output logic [3:0]      mst_ar_region_o,
    output logic [UW-1:0]   mst_ar_user_o,
    output logic            mst_ar_valid_o,
    input  logic            mst_ar_ready_i,
    input  logic [IW-1:0]   mst_r_id_i,
    input  logic [DW-1:0]   mst_r_data_i,
    input  logic [1:0]      mst_r_resp_i,
    input  logic            mst_r_last_i,
    input  logic [UW-1:0]   mst_r_user_i,
    input  logic            mst_r_valid_i,
    output logic            mst_r_ready_o
);
    // Size and burst travel through the payload registers. This makes every
    // data output read 0 after reset and the constant only once a beat loads.
    localparam logic [2:0] BEAT_SIZE = 3'($clog2(DW / 8));
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam int AXW = AW + 12;
    localparam int WW  = DW + DW / 8 + 1;

    logic [AXW-1:0] aw_in, aw_out, ar_in, ar_out;
    logic [WW-1:0]  w_in, w_out;
    logic [1:0]     b_resp_in;
    logic [DW+1:0]  r_in, r_out;
    logic           unused_fields;

    // Fields this bridge never looks at in the default build.
    assign unused_fields = ^{mst_b_id_i, mst_b_user_i, mst_r_id_i, mst_r_last_i, mst_r_user_i};

    assign aw_in = {slv_aw_addr_i, slv_aw_prot_i, slv_aw_cache_i, BEAT_SIZE, BURST_INCR};
    assign ar_in = {slv_ar_addr_i, slv_ar_prot_i, slv_ar_cache_i, BEAT_SIZE, BURST_INCR};
    assign w_in  = {slv_w_data_i, slv_w_strb_i, 1'b1};

`ifdef AXI_LITE_TO_AXI_RESP_CHECK_EN
    assign b_resp_in = (mst_b_id_i != '0) ? 2'b10 : mst_b_resp_i;
    assign r_in      = {mst_r_data_i,
                        ((mst_r_id_i != '0) || !mst_r_last_i) ? 2'b10 : mst_r_resp_i};
`else
    assign b_resp_in = mst_b_resp_i;
    assign r_in      = {mst_r_data_i, mst_r_resp_i};
`endif

    axi_lite_to_axi_bridge_slice #(.W(AXW)) u_aw (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(slv_aw_valid_i), .in_ready_o(slv_aw_ready_o), .in_data_i(aw_in),
        .out_valid_o(mst_aw_valid_o), .out_ready_i(mst_aw_ready_i), .out_data_o(aw_out)
    );

    axi_lite_to_axi_bridge_slice #(.W(WW)) u_w (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(slv_w_valid_i), .in_ready_o(slv_w_ready_o), .in_data_i(w_in),
        .out_valid_o(mst_w_valid_o), .out_ready_i(mst_w_ready_i), .out_data_o(w_out)
    );

    axi_lite_to_axi_bridge_slice #(.W(2)) u_b (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(mst_b_valid_i), .in_ready_o(mst_b_ready_o), .in_data_i(b_resp_in),
        .out_valid_o(slv_b_valid_o), .out_ready_i(slv_b_ready_i), .out_data_o(slv_b_resp_o)
    );

    axi_lite_to_axi_bridge_slice #(.W(AXW)) u_ar (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(slv_ar_valid_i), .in_ready_o(slv_ar_ready_o), .in_data_i(ar_in),
        .out_valid_o(mst_ar_valid_o), .out_ready_i(mst_ar_ready_i), .out_data_o(ar_out)
    );

    axi_lite_to_axi_bridge_slice #(.W(DW + 2)) u_r (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(mst_r_valid_i), .in_ready_o(mst_r_ready_o), .in_data_i(r_in),
        .out_valid_o(slv_r_valid_o), .out_ready_i(slv_r_ready_i), .out_data_o(r_out)
    );

    assign {mst_aw_addr_o, mst_aw_prot_o, mst_aw_cache_o, mst_aw_size_o, mst_aw_burst_o} = aw_out;
    assign {mst_ar_addr_o, mst_ar_prot_o, mst_ar_cache_o, mst_ar_size_o, mst_ar_burst_o} = ar_out;
    assign {mst_w_data_o, mst_w_strb_o, mst_w_last_o} = w_out;
    assign {slv_r_data_o, slv_r_resp_o} = r_out;

    // Single-beat, ID-0, unlocked, default-QoS transactions.
    assign mst_aw_id_o     = '0;
    assign mst_aw_len_o    = 8'h00;
    assign mst_aw_lock_o   = 1'b0;
    assign mst_aw_qos_o    = 4'h0;
    assign mst_aw_region_o = 4'h0;
    assign mst_aw_atop_o   = 6'h00;
    assign mst_aw_user_o   = '0;
    assign mst_ar_id_o     = '0;
    assign mst_ar_len_o    = 8'h00;
    assign mst_ar_lock_o   = 1'b0;
    assign mst_ar_qos_o    = 4'h0;
    assign mst_ar_region_o = 4'h0;
    assign mst_ar_user_o   = '0;
    assign mst_w_user_o    = '0;
endmodule

// File: tb/tb_axi_lite_to_axi_bridge.sv
// Directed testbench for axi_lite_to_axi_bridge (AW=DW=32, IW=UW=8).
module tb_axi_lite_to_axi_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] slv_aw_addr = '0;
    logic [2:0]  slv_aw_prot = '0;
    logic [3:0]  slv_aw_cache = '0;
    logic        slv_aw_valid = 1'b0, slv_aw_ready;
    logic [31:0] slv_w_data = '0;
    logic [3:0]  slv_w_strb = '0;
    logic        slv_w_valid = 1'b0, slv_w_ready;
    logic [1:0]  slv_b_resp;
    logic        slv_b_valid, slv_b_ready = 1'b1;
    logic [31:0] slv_ar_addr = '0;
    logic [2:0]  slv_ar_prot = '0;
    logic [3:0]  slv_ar_cache = '0;
    logic        slv_ar_valid = 1'b0, slv_ar_ready;
    logic [31:0] slv_r_data;
    logic [1:0]  slv_r_resp;
    logic        slv_r_valid, slv_r_ready = 1'b1;
    logic [7:0]  mst_aw_id, mst_aw_len, mst_aw_user;
    logic [31:0] mst_aw_addr;
    logic [2:0]  mst_aw_size, mst_aw_prot;
    logic [1:0]  mst_aw_burst;
    logic        mst_aw_lock, mst_aw_valid, mst_aw_ready = 1'b1;
    logic [3:0]  mst_aw_cache, mst_aw_qos, mst_aw_region;
    logic [5:0]  mst_aw_atop;
    logic [31:0] mst_w_data;
    logic [3:0]  mst_w_strb;
    logic        mst_w_last, mst_w_valid, mst_w_ready = 1'b1;
    logic [7:0]  mst_w_user;
    logic [7:0]  mst_b_id = '0, mst_b_user = '0;
    logic [1:0]  mst_b_resp = '0;
    logic        mst_b_valid = 1'b0, mst_b_ready;
    logic [7:0]  mst_ar_id, mst_ar_len, mst_ar_user;
    logic [31:0] mst_ar_addr;
    logic [2:0]  mst_ar_size, mst_ar_prot;
    logic [1:0]  mst_ar_burst;
    logic        mst_ar_lock, mst_ar_valid, mst_ar_ready = 1'b1;
    logic [3:0]  mst_ar_cache, mst_ar_qos, mst_ar_region;
    logic [7:0]  mst_r_id = '0, mst_r_user = '0;
    logic [31:0] mst_r_data = '0;
    logic [1:0]  mst_r_resp = '0;
    logic        mst_r_last = 1'b1, mst_r_valid = 1'b0, mst_r_ready;

    int errors = 0;
    int checks = 0;

`ifdef AXI_LITE_TO_AXI_RESP_CHECK_EN
    localparam logic [1:0] EXP_BAD_RESP = 2'b10;
`else
    localparam logic [1:0] EXP_BAD_RESP = 2'b00;
`endif

    always #5 clk = ~clk;

    axi_lite_to_axi_bridge dut (
        .clk_i(clk), .rst_i(rst),
        .slv_aw_addr_i(slv_aw_addr), .slv_aw_prot_i(slv_aw_prot), .slv_aw_cache_i(slv_aw_cache),
        .slv_aw_valid_i(slv_aw_valid), .slv_aw_ready_o(slv_aw_ready),
        .slv_w_data_i(slv_w_data), .slv_w_strb_i(slv_w_strb),
        .slv_w_valid_i(slv_w_valid), .slv_w_ready_o(slv_w_ready),
        .slv_b_resp_o(slv_b_resp), .slv_b_valid_o(slv_b_valid), .slv_b_ready_i(slv_b_ready),
        .slv_ar_addr_i(slv_ar_addr), .slv_ar_prot_i(slv_ar_prot), .slv_ar_cache_i(slv_ar_cache),
        .slv_ar_valid_i(slv_ar_valid), .slv_ar_ready_o(slv_ar_ready),
        .slv_r_data_o(slv_r_data), .slv_r_resp_o(slv_r_resp),
        .slv_r_valid_o(slv_r_valid), .slv_r_ready_i(slv_r_ready),
        .mst_aw_id_o(mst_aw_id), .mst_aw_addr_o(mst_aw_addr), .mst_aw_len_o(mst_aw_len),
        .mst_aw_size_o(mst_aw_size), .mst_aw_burst_o(mst_aw_burst), .mst_aw_lock_o(mst_aw_lock),
        .mst_aw_cache_o(mst_aw_cache), .mst_aw_prot_o(mst_aw_prot), .mst_aw_qos_o(mst_aw_qos),
        .mst_aw_region_o(mst_aw_region), .mst_aw_atop_o(mst_aw_atop), .mst_aw_user_o(mst_aw_user),
        .mst_aw_valid_o(mst_aw_valid), .mst_aw_ready_i(mst_aw_ready),
        .mst_w_data_o(mst_w_data), .mst_w_strb_o(mst_w_strb), .mst_w_last_o(mst_w_last),
        .mst_w_user_o(mst_w_user), .mst_w_valid_o(mst_w_valid), .mst_w_ready_i(mst_w_ready),
        .mst_b_id_i(mst_b_id), .mst_b_resp_i(mst_b_resp), .mst_b_user_i(mst_b_user),
        .mst_b_valid_i(mst_b_valid), .mst_b_ready_o(mst_b_ready),
        .mst_ar_id_o(mst_ar_id), .mst_ar_addr_o(mst_ar_addr), .mst_ar_len_o(mst_ar_len),
        .mst_ar_size_o(mst_ar_size), .mst_ar_burst_o(mst_ar_burst), .mst_ar_lock_o(mst_ar_lock),
        .mst_ar_cache_o(mst_ar_cache), .mst_ar_prot_o(mst_ar_prot), .mst_ar_qos_o(mst_ar_qos),
        .mst_ar_region_o(mst_ar_region), .mst_ar_user_o(mst_ar_user),
        .mst_ar_valid_o(mst_ar_valid), .mst_ar_ready_i(mst_ar_ready),
        .mst_r_id_i(mst_r_id), .mst_r_data_i(mst_r_data), .mst_r_resp_i(mst_r_resp),
        .mst_r_last_i(mst_r_last), .mst_r_user_i(mst_r_user),
        .mst_r_valid_i(mst_r_valid), .mst_r_ready_o(mst_r_ready)
    );

    // One clock, then settle 1 ns past the edge before driving or sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({slv_aw_ready, slv_w_ready, slv_ar_ready, mst_b_ready, mst_r_ready} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ready_low: got %b expected 00000",
                     {slv_aw_ready, slv_w_ready, slv_ar_ready, mst_b_ready, mst_r_ready});
        end
        checks++;
        if ({mst_aw_valid, mst_w_valid, mst_ar_valid, slv_b_valid, slv_r_valid} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_valid_low: got %b expected 00000",
                     {mst_aw_valid, mst_w_valid, mst_ar_valid, slv_b_valid, slv_r_valid});
        end
        checks++;
        if ({mst_aw_addr, mst_aw_size, mst_w_data, mst_w_last, slv_r_data, slv_b_resp} !== '0) begin
            errors++;
            $display("FAIL reset_data_zero: aw_addr=%h size=%0d w_data=%h last=%b r_data=%h b_resp=%0d expected all 0",
                     mst_aw_addr, mst_aw_size, mst_w_data, mst_w_last, slv_r_data, slv_b_resp);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({slv_aw_ready, slv_w_ready, slv_ar_ready, mst_b_ready, mst_r_ready} !== 5'b11111) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 11111",
                     {slv_aw_ready, slv_w_ready, slv_ar_ready, mst_b_ready, mst_r_ready});
        end
    endtask

    task automatic test_write();
        step();
        slv_aw_addr = 32'hDEADBEEF; slv_aw_prot = 3'd0; slv_aw_cache = 4'h0; slv_aw_valid = 1'b1;
        slv_w_data = 32'hDEADBEEF; slv_w_strb = 4'hF; slv_w_valid = 1'b1;
        step();
        slv_aw_valid = 1'b0; slv_w_valid = 1'b0;
        checks++;
        if ({mst_aw_valid, mst_aw_addr, mst_aw_prot} !== {1'b1, 32'hDEADBEEF, 3'd0}) begin
            errors++;
            $display("FAIL write_aw: got valid=%b addr=%h prot=%0d expected 1 deadbeef 0",
                     mst_aw_valid, mst_aw_addr, mst_aw_prot);
        end
        checks++;
        if ({mst_aw_id, mst_aw_len, mst_aw_size, mst_aw_burst, mst_aw_lock, mst_aw_cache,
             mst_aw_qos, mst_aw_region, mst_aw_atop, mst_aw_user}
            !== {8'h00, 8'h00, 3'd2, 2'b01, 1'b0, 4'h0, 4'h0, 4'h0, 6'h00, 8'h00}) begin
            errors++;
            $display("FAIL write_aw_const: id=%h len=%h size=%0d burst=%0d lock=%b cache=%h qos=%h region=%h atop=%h user=%h expected 0 0 2 1 0 0 0 0 0 0",
                     mst_aw_id, mst_aw_len, mst_aw_size, mst_aw_burst, mst_aw_lock, mst_aw_cache,
                     mst_aw_qos, mst_aw_region, mst_aw_atop, mst_aw_user);
        end
        checks++;
        if ({mst_w_valid, mst_w_data, mst_w_strb, mst_w_last, mst_w_user}
            !== {1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL write_w: valid=%b data=%h strb=%h last=%b user=%h expected 1 deadbeef f 1 00",
                     mst_w_valid, mst_w_data, mst_w_strb, mst_w_last, mst_w_user);
        end
        step();
        checks++;
        if ({mst_aw_valid, mst_w_valid} !== 2'b00) begin
            errors++;
            $display("FAIL write_drain: aw_valid=%b w_valid=%b expected 0 0", mst_aw_valid, mst_w_valid);
        end
        mst_b_id = 8'd0; mst_b_resp = 2'b00; mst_b_valid = 1'b1;
        step();
        mst_b_valid = 1'b0;
        checks++;
        if ({slv_b_valid, slv_b_resp} !== {1'b1, 2'b00}) begin
            errors++;
            $display("FAIL write_b: valid=%b resp=%0d expected 1 0", slv_b_valid, slv_b_resp);
        end
        step();
        checks++;
        if (slv_b_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_b_drain: valid=%b expected 0", slv_b_valid);
        end
    endtask

    task automatic test_read();
        slv_ar_addr = 32'h0000_1000; slv_ar_prot = 3'b010; slv_ar_cache = 4'h3; slv_ar_valid = 1'b1;
        step();
        slv_ar_valid = 1'b0;
        checks++;
        if ({mst_ar_valid, mst_ar_addr, mst_ar_prot, mst_ar_cache, mst_ar_len, mst_ar_size, mst_ar_burst, mst_ar_id}
            !== {1'b1, 32'h0000_1000, 3'd2, 4'h3, 8'h00, 3'd2, 2'b01, 8'h00}) begin
            errors++;
            $display("FAIL read_ar: valid=%b addr=%h prot=%0d cache=%h len=%0d size=%0d burst=%0d id=%0d expected 1 00001000 2 3 0 2 1 0",
                     mst_ar_valid, mst_ar_addr, mst_ar_prot, mst_ar_cache, mst_ar_len, mst_ar_size,
                     mst_ar_burst, mst_ar_id);
        end
        mst_r_id = 8'd0; mst_r_data = 32'h12345678; mst_r_resp = 2'b00; mst_r_last = 1'b1; mst_r_valid = 1'b1;
        step();
        mst_r_valid = 1'b0;
        checks++;
        if ({slv_r_valid, slv_r_data, slv_r_resp} !== {1'b1, 32'h12345678, 2'b00}) begin
            errors++;
            $display("FAIL read_r: valid=%b data=%h resp=%0d expected 1 12345678 0",
                     slv_r_valid, slv_r_data, slv_r_resp);
        end
        step();
    endtask

    task automatic test_backpressure();
        mst_aw_ready = 1'b0;
        slv_aw_addr = 32'h0000_0100; slv_aw_prot = 3'd0; slv_aw_cache = 4'h0; slv_aw_valid = 1'b1;
        step();
        slv_aw_addr = 32'h0000_0200;
        checks++;
        if (slv_aw_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_low: got %b expected 0", slv_aw_ready);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({mst_aw_valid, mst_aw_addr} !== {1'b1, 32'h0000_0100}) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b addr=%h expected 1 00000100", i, mst_aw_valid, mst_aw_addr);
            end
            step();
        end
        mst_aw_ready = 1'b1;
        #1;
        checks++;
        if (slv_aw_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_pass: got %b expected 1", slv_aw_ready);
        end
        step();
        slv_aw_valid = 1'b0;
        checks++;
        if ({mst_aw_valid, mst_aw_addr} !== {1'b1, 32'h0000_0200}) begin
            errors++;
            $display("FAIL bp_second: valid=%b addr=%h expected 1 00000200", mst_aw_valid, mst_aw_addr);
        end
        step();
        checks++;
        if (mst_aw_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: valid=%b expected 0", mst_aw_valid);
        end
    endtask

    task automatic test_w_before_aw();
        mst_w_ready = 1'b0; mst_aw_ready = 1'b0;
        slv_w_data = 32'h11223344; slv_w_strb = 4'h3; slv_w_valid = 1'b1;
        step();
        slv_w_valid = 1'b0;
        checks++;
        if ({mst_w_valid, mst_w_data, mst_w_strb, mst_aw_valid} !== {1'b1, 32'h11223344, 4'h3, 1'b0}) begin
            errors++;
            $display("FAIL wfirst_w: w_valid=%b data=%h strb=%h aw_valid=%b expected 1 11223344 3 0",
                     mst_w_valid, mst_w_data, mst_w_strb, mst_aw_valid);
        end
        step();
        step();
        slv_aw_addr = 32'h0000_2000; slv_aw_cache = 4'h5; slv_aw_valid = 1'b1;
        step();
        slv_aw_valid = 1'b0;
        checks++;
        if ({mst_aw_valid, mst_aw_addr, mst_aw_cache, mst_w_valid, mst_w_data}
            !== {1'b1, 32'h0000_2000, 4'h5, 1'b1, 32'h11223344}) begin
            errors++;
            $display("FAIL wfirst_aw: aw_valid=%b addr=%h cache=%h w_valid=%b w_data=%h expected 1 00002000 5 1 11223344",
                     mst_aw_valid, mst_aw_addr, mst_aw_cache, mst_w_valid, mst_w_data);
        end
        mst_w_ready = 1'b1; mst_aw_ready = 1'b1;
        step();
        checks++;
        if ({mst_aw_valid, mst_w_valid} !== 2'b00) begin
            errors++;
            $display("FAIL wfirst_drain: aw_valid=%b w_valid=%b expected 0 0", mst_aw_valid, mst_w_valid);
        end
    endtask

    task automatic test_reset_mid();
        mst_w_ready = 1'b0;
        slv_w_data = 32'hCAFEF00D; slv_w_strb = 4'hF; slv_w_valid = 1'b1;
        step();
        slv_w_valid = 1'b0;
        checks++;
        if ({mst_w_valid, mst_w_data} !== {1'b1, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL rstmid_loaded: valid=%b data=%h expected 1 cafef00d", mst_w_valid, mst_w_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (slv_w_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready: got %b expected 0", slv_w_ready);
        end
        step();
        checks++;
        if ({mst_w_valid, mst_w_data} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rstmid_cleared: valid=%b data=%h expected 0 00000000", mst_w_valid, mst_w_data);
        end
        rst = 1'b0; mst_w_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (mst_w_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_replay cycle %0d: valid=%b expected 0", i, mst_w_valid);
            end
        end
    endtask

    task automatic test_resp_check();
        mst_b_id = 8'd5; mst_b_resp = 2'b00; mst_b_valid = 1'b1;
        step();
        mst_b_valid = 1'b0; mst_b_id = 8'd0;
        checks++;
        if ({slv_b_valid, slv_b_resp} !== {1'b1, EXP_BAD_RESP}) begin
            errors++;
            $display("FAIL resp_b_id: valid=%b resp=%0d expected 1 %0d", slv_b_valid, slv_b_resp, EXP_BAD_RESP);
        end
        mst_r_id = 8'd0; mst_r_data = 32'hA5A5A5A5; mst_r_resp = 2'b00; mst_r_last = 1'b0; mst_r_valid = 1'b1;
        step();
        mst_r_valid = 1'b0; mst_r_last = 1'b1;
        checks++;
        if ({slv_r_valid, slv_r_data, slv_r_resp} !== {1'b1, 32'hA5A5A5A5, EXP_BAD_RESP}) begin
            errors++;
            $display("FAIL resp_r_last: valid=%b data=%h resp=%0d expected 1 a5a5a5a5 %0d",
                     slv_r_valid, slv_r_data, slv_r_resp, EXP_BAD_RESP);
        end
        step();
    endtask

    task automatic test_back_to_back();
        mst_r_id = 8'd0; mst_r_last = 1'b1;
        mst_r_data = 32'h0000_0001; mst_r_resp = 2'b11; mst_r_valid = 1'b1;
        step();
        mst_r_data = 32'h0000_0002; mst_r_resp = 2'b01;
        checks++;
        if ({slv_r_valid, slv_r_data, slv_r_resp, mst_r_ready} !== {1'b1, 32'h1, 2'b11, 1'b1}) begin
            errors++;
            $display("FAIL b2b_first: valid=%b data=%h resp=%0d mst_ready=%b expected 1 00000001 3 1",
                     slv_r_valid, slv_r_data, slv_r_resp, mst_r_ready);
        end
        step();
        mst_r_valid = 1'b0;
        checks++;
        if ({slv_r_valid, slv_r_data, slv_r_resp} !== {1'b1, 32'h2, 2'b01}) begin
            errors++;
            $display("FAIL b2b_second: valid=%b data=%h resp=%0d expected 1 00000002 1",
                     slv_r_valid, slv_r_data, slv_r_resp);
        end
        step();
        checks++;
        if (slv_r_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: valid=%b expected 0", slv_r_valid);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_w_before_aw();
        test_reset_mid();
        test_resp_check();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_lite_to_axi_bridge.md
Name: axi_lite_to_axi_bridge

Overview:
- Clocked protocol bridge: AXI4-Lite slave port in, full AXI4 master port out (one beat per transaction).
- Sits between AXI-Lite masters (e.g. config/DV drivers) and an AXI4 crossbar or memory.
- Fills every AXI4-only field with a constant and cuts all five channels with one register stage each.

Parameters:
- AW, 32, address width (both ports).
- DW, 32, data width (both ports); power of two, at least 8.
- IW, 8, AXI4 ID width.
- UW, 8, AXI4 user width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- slv_aw_addr_i/prot_i/valid_i, slv_aw_ready_o  in/in/in/out  AW/3/1/1  AXI-Lite AW
- slv_w_data_i/strb_i/valid_i, slv_w_ready_o  in/in/in/out  DW/DW/8/1/1  AXI-Lite W
- slv_b_resp_o/valid_o, slv_b_ready_i  out/out/in  2/1/1  AXI-Lite B
- slv_ar_addr_i/prot_i/valid_i, slv_ar_ready_o  in/in/in/out  AW/3/1/1  AXI-Lite AR
- slv_r_data_o/resp_o/valid_o, slv_r_ready_i  out/out/out/in  DW/2/1/1  AXI-Lite R
- slv_aw_cache_i, slv_ar_cache_i  in  4  cache attributes for AW/AR
- mst_aw_id/addr/len/size/burst/lock/cache/prot/qos/region/atop/user_o, mst_aw_valid_o, mst_aw_ready_i  out…/in  IW/AW/8/3/2/1/4/3/4/4/6/UW/1/1  AXI4 AW
- mst_w_data/strb/last/user_o, mst_w_valid_o, mst_w_ready_i  out…/in  DW/DW/8/1/UW/1/1  AXI4 W
- mst_b_id_i/resp_i/user_i/valid_i, mst_b_ready_o  in…/out  IW/2/UW/1/1  AXI4 B
- mst_ar_* (same fields as AW, no atop), mst_ar_valid_o, mst_ar_ready_i  AXI4 AR
- mst_r_id/data/resp/last/user_i, mst_r_valid_i, mst_r_ready_o  in…/out  IW/DW/2/1/UW/1/1  AXI4 R

Behaviour:
- Each channel has a 1-entry register slice: full flag plus payload register.
  - upstream ready = !full || downstream ready, combinational from downstream ready only.
  - Load when upstream valid && upstream ready.
  - Output valid = full.
  - Simultaneous pop and push: payload replaced, full stays 1.
  - Payload only changes on load; valid is never retracted before the handshake.
- Latency: exactly 1 cycle per channel, input handshake to output valid.
- Channels are independent:
  - AW and W are not coupled; W may precede AW.
  - No outstanding-transaction limit or counter.
  - Ordering is preserved because all IDs are 0.
- AW/AR constant fields:
  - addr and prot copied from the slave port.
  - id=0, len=0, size=log2(DW/8) (DW=32 gives 2), burst=INCR (2'b01).
  - lock=0, qos=0, region=0, user=0, atop=0 (AW only).
  - cache = slv_aw_cache_i / slv_ar_cache_i, sampled together with addr.
- W: data and strb copied; last=1, user=0.
- B: resp forwarded; id and user ignored.
- R: data and resp forwarded; id, last and user ignored.
- Reset (synchronous, rst_i=1 at a clk_i edge):
  - All full flags and payload registers cleared.
  - All *_valid_o = 0; all data outputs = 0; all *_ready_o = 1 once reset is released.
  - Reset mid-transaction silently drops any buffered beat.
  - While rst_i=1, all *_ready_o = 0.
- Back-pressure: with the output slice full and downstream ready=0, upstream ready=0 and the payload is held stable.

Optional Feature:
- Macro AXI_LITE_TO_AXI_RESP_CHECK_EN.
- Defined:
  - A B beat with id != 0 is forwarded with resp forced to SLVERR (2'b10).
  - An R beat with id != 0 or last=0 is likewise forced to SLVERR; data is still forwarded.
  - Nothing else changes.
- Undefined: resp is passed through unchanged and id/last are not examined.

Test Plan:
- Write: Lite AW addr=0xDEADBEEF prot=0, W data=0xDEADBEEF strb=0xF, slave answers B OKAY -> AXI AW addr=0xDEADBEEF id=0 len=0 size=2 burst=1 cache=0; W data=0xDEADBEEF strb=0xF last=1; Lite B resp=0 one cycle after mst_b handshake.
- Read: Lite AR addr=0x1000 prot=3'b010, slv_ar_cache_i=4'h3; AXI R data=0x12345678 resp=OKAY last=1 -> AR addr=0x1000 prot=2 cache=3 len=0; Lite R data=0x12345678 resp=0.
- Back-pressure: mst_aw_ready_i=0 for 5 cycles with 2 AW pushed -> first AW held stable with valid=1, slv_aw_ready_o=0 after first accept; both AWs emitted in order after ready rises.
- W before AW: W beat issued 3 cycles ahead of AW -> both appear on the master port independently, each 1 cycle after its own handshake.
- Reset mid-op: assert rst_i while mst_w_valid_o=1 -> next cycle mst_w_valid_o=0, beat not replayed after reset release.
- With AXI_LITE_TO_AXI_RESP_CHECK_EN defined: B with id=5 resp=OKAY -> slv_b_resp_o=2'b10; R with last=0 -> slv_r_resp_o=2'b10.
